// File: rtl/isa_dma_controller.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | isa_dma_controller: 4-channel ISA single-cycle DMA sequencer (DRQ1/3/5/7). |
// | Rev 1.0 -- define DMA_ROUND_ROBIN_EN for round-robin arbitration.         |
// +---------------------------------------------------------------------------+
module isa_dma_controller #(
  parameter int SYNC_STAGES   = 2,
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  drq,
  input  logic        pio_busy,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_ch,
  input  logic [15:0] cfg_count,
  input  logic        cfg_dir,
  output logic [3:0]  mask,
  input  logic        tx_valid,
  input  logic [15:0] tx_data,
  output logic        tx_ready,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        data_oe,
  output logic        rx_valid,
  output logic [15:0] rx_data,
  output logic [1:0]  rx_ch,
  output logic [3:0]  dack_n,
  output logic        aen,
  output logic        ior_n,
  output logic        iow_n,
  output logic        tc,
  output logic        dma_active,
  output logic [1:0]  active_ch
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETUP   = 3'd1;
  localparam logic [2:0] S_STROBE  = 3'd2;
  localparam logic [2:0] S_HOLD    = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;

  localparam logic [7:0] c_SETUP_LAST  = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] c_STROBE_LAST = 8'(STROBE_CYCLES - 1);

  logic [2:0]  r_state;
  logic [7:0]  r_cyc;
  logic [3:0]  r_sync [SYNC_STAGES];
  logic [15:0] r_count [4];
  logic [3:0]  r_dir;
  logic        r_xdir;

  logic [3:0]  w_elig;
  logic [1:0]  w_start;
  logic [1:0]  w_idx;
  logic [1:0]  w_win;
  logic        w_found;
  logic        w_grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= 4'h0;
    end else begin
      r_sync[0] <= drq;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_elig  = r_sync[SYNC_STAGES-1] & ~mask & (~r_dir | {4{tx_valid}});
  assign w_grant = (r_state == S_IDLE) && w_found && !pio_busy;

`ifdef DMA_ROUND_ROBIN_EN
  logic [1:0] r_rr_next;
  assign w_start = r_rr_next;
  always_ff @(posedge clk) begin
    if (reset)        r_rr_next <= 2'd0;
    else if (w_grant) r_rr_next <= w_win + 2'd1;
  end
`else
  assign w_start = 2'd0;
`endif

  // Search the four channels starting at w_start; first eligible one wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = 2'd0;
    w_idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      w_idx = w_start + 2'(k);
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cyc      <= 8'd0;
      r_xdir     <= 1'b0;
      r_dir      <= 4'h0;
      for (int i = 0; i < 4; i++) r_count[i] <= 16'h0;
      mask       <= 4'hF;
      dack_n     <= 4'hF;
      aen        <= 1'b0;
      ior_n      <= 1'b1;
      iow_n      <= 1'b1;
      data_oe    <= 1'b0;
      data_out   <= 16'h0;
      tc         <= 1'b0;
      tx_ready   <= 1'b0;
      rx_valid   <= 1'b0;
      rx_data    <= 16'h0;
      rx_ch      <= 2'd0;
      dma_active <= 1'b0;
      active_ch  <= 2'd0;
    end else begin
      tx_ready <= 1'b0;
      rx_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_state    <= S_SETUP;
            r_cyc      <= 8'd0;
            active_ch  <= w_win;
            r_xdir     <= r_dir[w_win];
            aen        <= 1'b1;
            dack_n     <= ~(4'b0001 << w_win);
            dma_active <= 1'b1;
            if (r_dir[w_win]) begin
              data_oe  <= 1'b1;
              data_out <= tx_data;
            end
          end
        end
        S_SETUP: begin
          if (r_cyc == c_SETUP_LAST) begin
            r_state  <= S_STROBE;
            r_cyc    <= 8'd0;
            tc       <= (r_count[active_ch] == 16'h0);
            tx_ready <= r_xdir;
            if (r_xdir) iow_n <= 1'b0;
            else        ior_n <= 1'b0;
          end else begin
            r_cyc <= r_cyc + 8'd1;
          end
        end
        S_STROBE: begin
          if (r_cyc == c_STROBE_LAST) begin
            r_state <= S_HOLD;
            iow_n   <= 1'b1;
            ior_n   <= 1'b1;
            tc      <= 1'b0;
            if (!r_xdir) begin
              rx_data  <= data_in;
              rx_ch    <= active_ch;
              rx_valid <= 1'b1;
            end
          end else begin
            r_cyc <= r_cyc + 8'd1;
          end
        end
        S_HOLD: r_state <= S_RELEASE;
        S_RELEASE: begin
          r_state    <= S_IDLE;
          dack_n     <= 4'hF;
          aen        <= 1'b0;
          data_oe    <= 1'b0;
          dma_active <= 1'b0;
          if (r_count[active_ch] == 16'h0) mask[active_ch] <= 1'b1;
          else r_count[active_ch] <= r_count[active_ch] - 16'd1;
        end
        default: r_state <= S_IDLE;
      endcase
      // Issued last so a config write beats the release-time count/mask update.
      if (cfg_we) begin
        r_count[cfg_ch] <= cfg_count;
        r_dir[cfg_ch]   <= cfg_dir;
        mask[cfg_ch]    <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_isa_dma_controller.sv
`default_nettype none
// tb_isa_dma_controller: directed steps with a read-data scoreboard.
module tb_isa_dma_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  drq = 4'h0;
  logic        pio_busy = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_ch = 2'd0;
  logic [15:0] cfg_count = 16'h0;
  logic        cfg_dir = 1'b0;
  logic        tx_valid = 1'b0;
  logic [15:0] tx_data = 16'h0;
  logic [15:0] data_in = 16'h0;
  logic [3:0]  mask;
  logic        tx_ready;
  logic [15:0] data_out;
  logic        data_oe;
  logic        rx_valid;
  logic [15:0] rx_data;
  logic [1:0]  rx_ch;
  logic [3:0]  dack_n;
  logic        aen;
  logic        ior_n;
  logic        iow_n;
  logic        tc;
  logic        dma_active;
  logic [1:0]  active_ch;

  isa_dma_controller #(.SYNC_STAGES(2), .SETUP_CYCLES(1), .STROBE_CYCLES(3)) dut (
    .clk(clk), .reset(reset), .drq(drq), .pio_busy(pio_busy),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_count(cfg_count), .cfg_dir(cfg_dir),
    .mask(mask), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ch(rx_ch),
    .dack_n(dack_n), .aen(aen), .ior_n(ior_n), .iow_n(iow_n), .tc(tc),
    .dma_active(dma_active), .active_ch(active_ch)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] d; logic [1:0] ch; } rx_t;
  rx_t sb[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  int  n_unexp  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [15:0] cnt, input logic dir);
    cfg_we = 1'b1; cfg_ch = ch; cfg_count = cnt; cfg_dir = dir;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic push_rx(input logic [15:0] d, input logic [1:0] ch);
    rx_t e;
    e.d = d; e.ch = ch;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      if (sb.size() == 0) n_unexp++;
      else begin
        rx_t e;
        e = sb.pop_front();
        chk("rx_data", {16'h0, rx_data}, {16'h0, e.d});
        chk("rx_ch", {30'h0, rx_ch}, {30'h0, e.ch});
      end
    end
  end

  initial begin : main
    int aen_n, dk_n, iow_lo, ior_lo, txr_n, tc_n, tc_bad, oe_n, oe_bad;
    int xfer, tc_x1, tc_x2, t;
    logic prev_aen;
    logic [1:0] gq[$];
    logic [1:0] exp_ch;

    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("rst_dack_n", {28'h0, dack_n}, 32'hF);
    chk("rst_aen", {31'h0, aen}, 32'h0);
    chk("rst_strobes", {30'h0, ior_n, iow_n}, 32'h3);
    chk("rst_data", {15'h0, data_oe, data_out}, 32'h0);
    chk("rst_misc", {27'h0, tc, tx_ready, rx_valid, dma_active, 1'b0}, 32'h0);
    chk("rst_rx", {14'h0, rx_ch, rx_data}, 32'h0);
    chk("rst_active_ch", {30'h0, active_ch}, 32'h0);
    chk("rst_mask", {28'h0, mask}, 32'hF);
    reset = 1'b0;
    drq = 4'hF;
    cycles(8);
    chk("masked_no_dack", {28'h0, dack_n}, 32'hF);
    chk("masked_idle", {31'h0, dma_active}, 32'h0);
    drq = 4'h0;
    cycles(3);

    // Write transfer on channel 1.
    cfg(2'd1, 16'd0, 1'b1);
    tx_data = 16'h1234; tx_valid = 1'b1; drq = 4'b0010;
    {aen_n, dk_n, iow_lo, ior_lo, txr_n, tc_n, tc_bad, oe_n, oe_bad} = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (aen) aen_n++;
      if (dack_n == 4'b1101) dk_n++;
      if (!iow_n) iow_lo++;
      if (!ior_n) ior_lo++;
      if (tx_ready) txr_n++;
      if (tc) tc_n++;
      if (tc && iow_n) tc_bad++;
      if (data_oe) oe_n++;
      if (data_oe && data_out != 16'h1234) oe_bad++;
    end
    chk("wr_aen_cycles", aen_n, 6);
    chk("wr_dack1_cycles", dk_n, 6);
    chk("wr_iow_cycles", iow_lo, 3);
    chk("wr_no_ior", ior_lo, 0);
    chk("wr_tx_ready_pulses", txr_n, 1);
    chk("wr_tc_cycles", tc_n, 3);
    chk("wr_tc_outside_strobe", tc_bad, 0);
    chk("wr_oe_cycles", oe_n, 6);
    chk("wr_data_out_bad", oe_bad, 0);
    chk("wr_mask1", {31'h0, mask[1]}, 32'h1);
    drq = 4'h0; tx_valid = 1'b0;
    cycles(2);

    // Read transfers on channel 2, two words.
    cfg(2'd2, 16'd1, 1'b0);
    data_in = 16'hA55A;
    push_rx(16'hA55A, 2'd2);
    push_rx(16'hA55A, 2'd2);
    drq = 4'b0100;
    xfer = 0; tc_x1 = 0; tc_x2 = 0; prev_aen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (aen && !prev_aen) xfer++;
      prev_aen = aen;
      if (tc && xfer == 1) tc_x1++;
      if (tc && xfer == 2) tc_x2++;
    end
    chk("rd_transfers", xfer, 2);
    chk("rd_tc_first", tc_x1, 0);
    chk("rd_tc_second", tc_x2, 3);
    chk("rd_mask2", {31'h0, mask[2]}, 32'h1);
    chk("rd_sb_drained", sb.size(), 0);
    drq = 4'h0;

    // Contention from a fresh reset so the arbiter starts at channel 0.
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) cfg(2'(c), 16'd3, 1'b0);
    data_in = 16'hBEEF;
    for (int i = 0; i < 16; i++) begin
`ifdef DMA_ROUND_ROBIN_EN
      exp_ch = 2'(i % 4);
`else
      exp_ch = 2'(i / 4);
`endif
      push_rx(16'hBEEF, exp_ch);
    end
    drq = 4'hF;
    prev_aen = 1'b0;
    for (int i = 0; i < 140; i++) begin
      @(negedge clk);
      if (aen && !prev_aen) gq.push_back(active_ch);
      prev_aen = aen;
    end
    chk("cont_grants", gq.size(), 16);
    for (int i = 0; i < gq.size() && i < 16; i++) begin
`ifdef DMA_ROUND_ROBIN_EN
      exp_ch = 2'(i % 4);
`else
      exp_ch = 2'(i / 4);
`endif
      chk($sformatf("cont_grant_%0d", i), {30'h0, gq[i]}, {30'h0, exp_ch});
    end
    chk("cont_mask_all", {28'h0, mask}, 32'hF);
    drq = 4'h0;
    cycles(3);

    // Bus sharing with the PIO engine.
    cfg(2'd0, 16'd0, 1'b0);
    data_in = 16'h0F0F;
    push_rx(16'h0F0F, 2'd0);
    pio_busy = 1'b1;
    drq = 4'b0001;
    cycles(6);
    chk("pio_blocks_dack", {28'h0, dack_n}, 32'hF);
    chk("pio_blocks_active", {31'h0, dma_active}, 32'h0);
    pio_busy = 1'b0;
    @(negedge clk);
    chk("pio_release_dack", {28'h0, dack_n}, 32'hE);
    chk("pio_release_aen", {31'h0, aen}, 32'h1);
    pio_busy = 1'b1;
    cycles(8);
    chk("pio_late_ignored", {31'h0, dma_active}, 32'h0);
    chk("pio_mask0", {31'h0, mask[0]}, 32'h1);
    pio_busy = 1'b0; drq = 4'h0;
    cycles(2);

    // Reset in the middle of a write strobe.
    cfg(2'd3, 16'd5, 1'b1);
    tx_data = 16'h5A5A; tx_valid = 1'b1; drq = 4'b1000;
    t = 0;
    while (iow_n !== 1'b0 && t < 30) begin @(negedge clk); t++; end
    chk("rs_strobe_seen", {31'h0, (t < 30)}, 32'h1);
    @(negedge clk);
    chk("rs_second_strobe", {31'h0, iow_n}, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    chk("rs_iow", {31'h0, iow_n}, 32'h1);
    chk("rs_aen", {31'h0, aen}, 32'h0);
    chk("rs_dack", {28'h0, dack_n}, 32'hF);
    chk("rs_oe_tc", {30'h0, data_oe, tc}, 32'h0);
    @(negedge clk);
    reset = 1'b0; drq = 4'h0; tx_valid = 1'b0;
    cycles(10);
    chk("rs_idle_after", {31'h0, dma_active}, 32'h0);

    chk("sb_empty", sb.size(), 0);
    chk("rx_unexpected", n_unexp, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
